uart_rx_cmd_dispatch: RTL and testbench

- Sits behind the UART frame receiver and consumes each CRC-validated frame (opt, len, data, valid pulse).
- Buffers frames in a small FIFO, decodes the target channel from the opt byte, and offers the frame to one of NUM_CH consumer channels using a valid/ready handshake.
- Frames are dispatched one at a time through a shared output bus.
- Rejects malformed frames, drops frames when the FIFO overflows or a channel times out, and counts every error.

---
 rtl/uart_rx_cmd_dispatch.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_cmd_dispatch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_dispatch.sv
// uart_rx_cmd_dispatch
// Buffers CRC-validated UART frames in a small FIFO, decodes the target
// channel from the opt byte and offers each frame to its consumer over a
// shared valid/ready bus. Malformed frames are rejected; FIFO overflow and
// offer timeouts drop frames. Every error is counted in a saturating counter.
// Optional broadcast support: define UART_DISPATCH_BCAST_EN.
module uart_rx_cmd_dispatch #(
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned DATA_SIZE      = 64,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [BYTE_SIZE-1:0] i_opt,
  input  logic [BYTE_SIZE-1:0] i_len,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_valid,
  input  logic [NUM_CH-1:0]    i_ch_ready,
  output logic [NUM_CH-1:0]    o_ch_valid,
  output logic [BYTE_SIZE-1:0] o_opt,
  output logic [BYTE_SIZE-1:0] o_len,
  output logic [DATA_SIZE-1:0] o_data,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic                 o_err,
  output logic                 o_timeout,
  output logic [7:0]           o_drop_cnt,
  output logic [7:0]           o_err_cnt
);

  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENT_W   = 2 * BYTE_SIZE + DATA_SIZE;
  localparam int unsigned MAX_LEN = DATA_SIZE / BYTE_SIZE;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  state_t               r_state;
  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [TO_W-1:0]      r_tcnt;
  logic [NUM_CH-1:0]    r_ch_valid;
  logic [BYTE_SIZE-1:0] r_opt;
  logic [BYTE_SIZE-1:0] r_len;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_ovf;
  logic                 r_err;
  logic                 r_timeout;
  logic [7:0]           r_drop_cnt;
  logic [7:0]           r_err_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf;
  logic [ENT_W-1:0]     w_head;
  logic [BYTE_SIZE-1:0] w_h_opt;
  logic [BYTE_SIZE-1:0] w_h_len;
  logic [DATA_SIZE-1:0] w_h_data;
  logic [NUM_CH-1:0]    w_onehot;
  logic [NUM_CH-1:0]    w_mask;
  logic [NUM_CH-1:0]    w_rem;
  logic                 w_len_bad;
  logic                 w_malformed;
  logic                 w_load_bad;
  logic                 w_done;
  logic                 w_to_hit;
  logic [TO_W-1:0]      w_tcnt_nxt;
  logic [8:0]           w_drop_sum;

  // FIFO status and head-entry decode
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rptr];
  assign {w_h_opt, w_h_len, w_h_data} = w_head;
  assign w_onehot  = NUM_CH'(1) << w_h_opt[CH_W-1:0];
  assign w_len_bad = (w_h_len == '0) || (w_h_len > BYTE_SIZE'(MAX_LEN));

`ifdef UART_DISPATCH_BCAST_EN
  assign w_mask      = w_h_opt[BYTE_SIZE-1] ? '1 : w_onehot;
  assign w_malformed = w_len_bad;
`else
  assign w_mask      = w_onehot;
  assign w_malformed = w_len_bad || w_h_opt[BYTE_SIZE-1];
`endif

  // r_ch_valid holds mask & ~accepted directly, so the channels still owed
  // after this cycle are the valid bits whose ready is low.
  assign w_rem      = r_ch_valid & ~i_ch_ready;
  assign w_load_bad = (r_state == ST_LOAD) && w_malformed;
  assign w_done     = (r_state == ST_OFFER) && (w_rem == '0);
  assign w_tcnt_nxt = r_tcnt + TO_W'(1);
  // Fires on the edge where the counter would reach TIMEOUT_CYCLES, so a
  // frame is offered for exactly TIMEOUT_CYCLES cycles before being dropped.
  assign w_to_hit   = (TIMEOUT_CYCLES != 0) && (r_state == ST_OFFER) && !w_done &&
                      (w_tcnt_nxt == TO_W'(TIMEOUT_CYCLES));
  assign w_pop      = w_load_bad || w_done || w_to_hit;
  assign w_push     = i_valid && (!w_full || w_pop);
  assign w_ovf      = i_valid && !w_push;
  assign w_drop_sum = 9'(r_drop_cnt) + 9'(w_ovf) + 9'(w_to_hit);

  // Frame storage; occupancy lives in r_count so no reset needed here
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= {i_opt, i_len, i_data};
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Dispatch FSM with registered output bus and event pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_ch_valid <= '0;
      r_opt      <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_opt  <= w_h_opt;
          r_len  <= w_h_len;
          r_data <= w_h_data;
          r_tcnt <= '0;
          if (w_malformed) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_ch_valid <= w_mask;
            r_state    <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (w_done) begin
            r_ch_valid <= '0;
            r_tcnt     <= '0;
            r_state    <= ST_IDLE;
          end else if (w_to_hit) begin
            r_ch_valid <= '0;
            r_tcnt     <= '0;
            r_timeout  <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_ch_valid <= w_rem;
            r_tcnt     <= w_tcnt_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Overflow pulse and saturating error/drop counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_ovf      <= w_ovf;
      r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
      if (w_load_bad && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_ch_valid = r_ch_valid;
  assign o_opt      = r_opt;
  assign o_len      = r_len;
  assign o_data     = r_data;
  assign o_busy     = !w_empty || (r_state != ST_IDLE);
  assign o_overflow = r_ovf;
  assign o_err      = r_err;
  assign o_timeout  = r_timeout;
  assign o_drop_cnt = r_drop_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_cmd_dispatch.sv
// Testbench for uart_rx_cmd_dispatch: scoreboard of expected frame outcomes
// (accept / reject / timeout) pushed at send time, popped by a monitor that
// watches handshakes and event pulses. Honours UART_DISPATCH_BCAST_EN.
module tb_uart_rx_cmd_dispatch;

  localparam int unsigned TMO = 8;
  localparam int K_ACC  = 0;
  localparam int K_ERR  = 1;
  localparam int K_TMO  = 2;
  localparam int K_OVF  = 3;
  localparam int K_NONE = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  i_opt;
  logic [7:0]  i_len;
  logic [63:0] i_data;
  logic        i_valid;
  logic [3:0]  i_ch_ready;
  logic [3:0]  o_ch_valid;
  logic [7:0]  o_opt;
  logic [7:0]  o_len;
  logic [63:0] o_data;
  logic        o_busy;
  logic        o_overflow;
  logic        o_err;
  logic        o_timeout;
  logic [7:0]  o_drop_cnt;
  logic [7:0]  o_err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  typedef struct {
    int          kind;
    logic [7:0]  opt;
    logic [7:0]  len;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned ovf_pend   = 0;
  int unsigned exp_drop   = 0;
  int unsigned exp_err    = 0;
  int unsigned err_pulses = 0;
  int unsigned vld_cycles = 0;
  logic [3:0]  rem        = '0;
  logic        rem_live   = 1'b0;
  logic [3:0]  pv         = '0;
  logic [3:0]  phs        = '0;
  logic [63:0] pdata      = '0;
  logic [3:0]  mon_hs;

  always #5 CLK = ~CLK;

  uart_rx_cmd_dispatch #(
    .BYTE_SIZE      (8),
    .DATA_SIZE      (64),
    .NUM_CH         (4),
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_opt      (i_opt),
    .i_len      (i_len),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_ch_ready (i_ch_ready),
    .o_ch_valid (o_ch_valid),
    .o_opt      (o_opt),
    .o_len      (o_len),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_err      (o_err),
    .o_timeout  (o_timeout),
    .o_drop_cnt (o_drop_cnt),
    .o_err_cnt  (o_err_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [7:0] opt);
`ifdef UART_DISPATCH_BCAST_EN
    if (opt[7]) return 4'hF;
`endif
    return 4'b0001 << opt[1:0];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one i_valid pulse; caller is positioned just after a rising edge.
  task automatic send(input logic [7:0] opt, input logic [7:0] len,
                      input logic [63:0] data, input int kind);
    exp_t e;
    i_opt   = opt;
    i_len   = len;
    i_data  = data;
    i_valid = 1'b1;
    e.kind = kind;
    e.opt  = opt;
    e.len  = len;
    e.data = data;
    case (kind)
      K_ACC: exp_q.push_back(e);
      K_ERR: begin exp_q.push_back(e); exp_err++; end
      K_TMO: begin exp_q.push_back(e); exp_drop++; end
      K_OVF: begin ovf_pend++; exp_drop++; end
      default: ;
    endcase
    @(posedge CLK);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (!o_busy && exp_q.size() == 0 && ovf_pend == 0) done = 1'b1;
    end
    check_eq("idle_reached", 64'(done), 64'd1);
  endtask

  // Monitor: pops scoreboard entries on handshakes and event pulses
  always @(negedge CLK) begin
    if (!RST_N) begin
      pv       = '0;
      phs      = '0;
      rem_live = 1'b0;
    end else begin
      mon_hs = o_ch_valid & i_ch_ready;
      if (|o_ch_valid) vld_cycles++;
      if (((pv & ~phs) != 4'b0) && !o_timeout) begin
        check_eq("hold_valid", 64'(o_ch_valid), 64'(pv & ~phs));
        check_eq("hold_data", o_data, pdata);
      end
      if (mon_hs != 4'b0) begin
        if (exp_q.size() == 0) begin
          check_eq("hs_unexpected", 64'(mon_hs), 64'd0);
        end else if (exp_q[0].kind != K_ACC) begin
          check_eq("hs_kind", 64'(exp_q[0].kind), 64'(K_ACC));
        end else begin
          if (!rem_live) begin
            rem      = exp_mask(exp_q[0].opt);
            rem_live = 1'b1;
          end
          check_eq("hs_chan", 64'(mon_hs & ~rem), 64'd0);
          check_eq("hs_opt", 64'(o_opt), 64'(exp_q[0].opt));
          check_eq("hs_len", 64'(o_len), 64'(exp_q[0].len));
          check_eq("hs_data", o_data, exp_q[0].data);
          rem = rem & ~mon_hs;
          if (rem == 4'b0) begin
            void'(exp_q.pop_front());
            rem_live = 1'b0;
          end
        end
      end
      if (o_err) begin
        err_pulses++;
        if (exp_q.size() == 0) begin
          check_eq("err_unexpected", 64'd1, 64'd0);
        end else begin
          check_eq("err_kind", 64'(exp_q[0].kind), 64'(K_ERR));
          check_eq("err_opt", 64'(o_opt), 64'(exp_q[0].opt));
          check_eq("err_len", 64'(o_len), 64'(exp_q[0].len));
          void'(exp_q.pop_front());
        end
      end
      if (o_timeout) begin
        if (exp_q.size() == 0) begin
          check_eq("tmo_unexpected", 64'd1, 64'd0);
        end else begin
          check_eq("tmo_kind", 64'(exp_q[0].kind), 64'(K_TMO));
          check_eq("tmo_opt", 64'(o_opt), 64'(exp_q[0].opt));
          void'(exp_q.pop_front());
          rem_live = 1'b0;
        end
      end
      if (o_overflow) begin
        check_eq("ovf_expected", 64'(ovf_pend != 0), 64'd1);
        if (ovf_pend != 0) ovf_pend--;
      end
      pv    = o_ch_valid;
      phs   = mon_hs;
      pdata = o_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    bit          found;
    int unsigned cnt;
    int          ord[4] = '{0, 2, 1, 3};

    i_opt = '0; i_len = '0; i_data = '0; i_valid = 1'b0; i_ch_ready = '0;
    repeat (3) @(negedge CLK);
    check_eq("rst_valid", 64'(o_ch_valid), 64'd0);
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_pulses", 64'({o_overflow, o_err, o_timeout}), 64'd0);
    check_eq("rst_cnts", 64'({o_drop_cnt, o_err_cnt}), 64'd0);
    check_eq("rst_bus", o_data | 64'({o_opt, o_len}), 64'd0);
    step();
    RST_N = 1'b1;
    step();

    // Basic dispatch and latency
    i_ch_ready = 4'b0100;
    send(8'h02, 8'd3, 64'hAABBCC, K_ACC);
    @(negedge CLK); check_eq("lat_n1", 64'(o_ch_valid), 64'd0);
    @(negedge CLK); check_eq("lat_n2", 64'(o_ch_valid), 64'd0);
    @(negedge CLK); check_eq("lat_n3", 64'(o_ch_valid), 64'h4);
    check_eq("lat_n3_data", o_data, 64'hAABBCC);
    @(negedge CLK); check_eq("lat_n4", 64'(o_ch_valid), 64'd0);
    @(negedge CLK); check_eq("busy_n5", 64'(o_busy), 64'd0);
    wait_idle();

    // Longest legal frame
    step();
    i_ch_ready = 4'b0001;
    send(8'h00, 8'd8, 64'h0123456789ABCDEF, K_ACC);
    wait_idle();

    // Overflow: third back-to-back frame lands on a full FIFO
    step();
    i_ch_ready = 4'b0000;
    send(8'h01, 8'd2, 64'h1111, K_ACC);
    send(8'h01, 8'd2, 64'h2222, K_ACC);
    send(8'h01, 8'd2, 64'h3333, K_OVF);
    @(negedge CLK);
    check_eq("ovf_pulse", 64'(o_overflow), 64'd1);
    check_eq("ovf_drop_cnt", 64'(o_drop_cnt), 64'd1);
    step();
    i_ch_ready = 4'b0010;
    wait_idle();
    check_eq("ovf_drop_final", 64'(o_drop_cnt), 64'(exp_drop));

    // Malformed lengths
    step();
    i_ch_ready = 4'hF;
    vld_cycles = 0;
    err_pulses = 0;
    send(8'h01, 8'd0, 64'h55, K_ERR);
    wait_idle();
    step();
    send(8'h02, 8'd9, 64'h66, K_ERR);
    wait_idle();
    check_eq("mal_no_valid", 64'(vld_cycles), 64'd0);
    check_eq("mal_pulses", 64'(err_pulses), 64'd2);
    check_eq("mal_err_cnt", 64'(o_err_cnt), 64'd2);

    // Timeout on ch3 with a second frame queued behind it
    step();
    i_ch_ready = 4'b0000;
    send(8'h03, 8'd1, 64'h5A, K_TMO);
    send(8'h03, 8'd2, 64'hBEEF, K_ACC);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (o_ch_valid[3]) found = 1'b1;
    end
    check_eq("tmo_offer_seen", 64'(found), 64'd1);
    cnt = 0;
    while (o_ch_valid[3] && cnt < 50) begin
      cnt++;
      @(negedge CLK);
    end
    check_eq("tmo_valid_cycles", 64'(cnt), 64'(TMO));
    check_eq("tmo_pulse", 64'(o_timeout), 64'd1);
    check_eq("tmo_drop_cnt", 64'(o_drop_cnt), 64'd2);
    step();
    i_ch_ready = 4'b1000;
    wait_idle();

    // Broadcast frame
    step();
    i_ch_ready = 4'b0000;
`ifdef UART_DISPATCH_BCAST_EN
    send(8'h80, 8'd4, 64'hCAFEF00D, K_ACC);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (o_ch_valid == 4'hF) found = 1'b1;
    end
    check_eq("bc_all_valid", 64'(found), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      i_ch_ready = 4'b0001 << ord[k];
    end
    step();
    i_ch_ready = 4'b0000;
    wait_idle();
`else
    send(8'h80, 8'd4, 64'hCAFEF00D, K_ERR);
    wait_idle();
    check_eq("bc_err_cnt", 64'(o_err_cnt), 64'd3);
    check_eq("bc_order_unused", 64'(ord[3]), 64'd3);
`endif

    // Reset asserted mid-offer
    step();
    i_ch_ready = 4'b0000;
    send(8'h01, 8'd1, 64'h77, K_NONE);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (o_ch_valid == 4'b0010) found = 1'b1;
    end
    check_eq("rmo_offer_seen", 64'(found), 64'd1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check_eq("rmo_valid", 64'(o_ch_valid), 64'd0);
    check_eq("rmo_busy", 64'(o_busy), 64'd0);
    check_eq("rmo_cnts", 64'({o_drop_cnt, o_err_cnt}), 64'd0);
    check_eq("rmo_bus", o_data | 64'({o_opt, o_len}), 64'd0);
    exp_q.delete();
    ovf_pend = 0;
    exp_drop = 0;
    exp_err  = 0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check_eq("rmo_post_busy", 64'(o_busy), 64'd0);
    check_eq("rmo_post_valid", 64'(o_ch_valid), 64'd0);
    step();
    i_ch_ready = 4'b0100;
    send(8'h02, 8'd2, 64'h1234, K_ACC);
    wait_idle();

    step();
    check_eq("end_queue", 64'(exp_q.size()), 64'd0);
    check_eq("end_ovf_pend", 64'(ovf_pend), 64'd0);
    check_eq("end_drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
    check_eq("end_err_cnt", 64'(o_err_cnt), 64'(exp_err));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
